// File: rtl/reaction_timer.sv
// Two-digit BCD reaction timer: a prescaler tick advances the count while the LED is lit.
// Optional macro REACTION_SATURATE_EN holds the count at 99 instead of wrapping to 00.
module reaction_timer #(
    parameter int PRESCALE_BITS = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       rst,
    output logic       c9,
    input  logic       w,
    input  logic       Pushn,
    output logic       LEDn,
    output logic [1:7] Digit1,
    output logic [1:7] Digit0
);

    typedef enum logic {
        LED_OFF,
        LED_ON
    } led_e;

    led_e                     ledState_q, ledState_d;
    logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
    logic [3:0]               tens_q, tens_d;
    logic [3:0]               ones_q, ones_d;
    logic                     tick;

    // Active-low abcdefg; codes 10..15 cannot occur and blank the digit.
    function automatic logic [1:7] seg7(input logic [3:0] v);
        logic [1:7] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            prescale_q <= '0;
            ledState_q <= LED_OFF;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
        end else begin
            prescale_q <= prescale_d;
            ledState_q <= ledState_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
        end
    end

    always_comb begin
        prescale_d = '0;
        if (rst) begin
            prescale_d = prescale_q + PRESCALE_BITS'(1);
        end
    end

    assign c9 = &prescale_q;

    // Stop button dominates the start request.
    always_comb begin
        ledState_d = ledState_q;
        if (!Pushn) begin
            ledState_d = LED_OFF;
        end else if (w) begin
            ledState_d = LED_ON;
        end
    end

    assign tick = (ledState_q == LED_ON) && c9;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (tick) begin
            if (ones_q == 4'd9) begin
                if (tens_q == 4'd9) begin
`ifdef REACTION_SATURATE_EN
                    tens_d = tens_q;
                    ones_d = ones_q;
`else
                    tens_d = 4'd0;
                    ones_d = 4'd0;
`endif
                end else begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    assign LEDn   = (ledState_q != LED_ON);
    assign Digit1 = seg7(tens_q);
    assign Digit0 = seg7(ones_q);

endmodule

// File: tb/tb_reaction_timer.sv
// Randomised scoreboard bench for reaction_timer: an integer-count reference model
// predicts each cycle's outputs into a queue that a free-running monitor drains.
module tb_reaction_timer;

    localparam int PB   = 3;
    localparam int PMOD = 1 << PB;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       rst;
    logic       c9;
    logic       w;
    logic       Pushn;
    logic       LEDn;
    logic [1:7] Digit1;
    logic [1:7] Digit0;

    typedef struct {
        logic       ledn;
        logic       c9;
        logic [6:0] d1;
        logic [6:0] d0;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stimDone = 0;

    // Reference state: prescaler phase, LED lit flag, count as a plain integer.
    int   modelP   = 0;
    bit   modelLit = 0;
    int   modelN   = 0;

    logic [6:0] segTab[10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    reaction_timer #(.PRESCALE_BITS(PB)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .rst   (rst),
        .c9    (c9),
        .w     (w),
        .Pushn (Pushn),
        .LEDn  (LEDn),
        .Digit1(Digit1),
        .Digit0(Digit0)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=%b required=%b at %0t", name, actual, required, $time);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.ledn = !modelLit;
        e.c9   = (modelP == PMOD - 1);
        e.d1   = segTab[modelN / 10];
        e.d0   = segTab[modelN % 10];
        return e;
    endfunction

    // Drives one cycle's inputs and queues the outputs expected after the next rising edge.
    task automatic applyStimulus(input bit rs, input bit rstv, input bit wv, input bit pn);
        bit tickNow;
        @(negedge Clock);
        Reset = rs;
        rst   = rstv;
        w     = wv;
        Pushn = pn;
        if (rs) begin
            modelP   = 0;
            modelLit = 0;
            modelN   = 0;
        end else begin
            tickNow = modelLit && (modelP == PMOD - 1);
            if (tickNow) begin
                if (modelN == 99) begin
`ifdef REACTION_SATURATE_EN
                    modelN = 99;
`else
                    modelN = 0;
`endif
                end else begin
                    modelN = modelN + 1;
                end
            end
            if (!pn)     modelLit = 0;
            else if (wv) modelLit = 1;
            modelP = rstv ? (modelP + 1) % PMOD : 0;
        end
        expQ.push_back(predict());
    endtask

    task automatic idle(input int n, input bit rstv);
        for (int i = 0; i < n; i++) applyStimulus(0, rstv, 0, 1);
    endtask

    task automatic runTo(input int target);
        int guard = 0;
        while (modelN != target && guard < 2000) begin
            applyStimulus(0, 1, 0, 1);
            guard++;
        end
        checkOutput("reach_count", 7'(modelN), 7'(target));
    endtask

    always begin
        exp_t e;
        @(posedge Clock);
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("LEDn",   7'(LEDn), 7'(e.ledn));
            checkOutput("c9",     7'(c9),   7'(e.c9));
            checkOutput("Digit1", Digit1,   e.d1);
            checkOutput("Digit0", Digit0,   e.d0);
        end
    end

    initial begin
        Reset = 1'b1;
        rst   = 1'b1;
        w     = 1'b0;
        Pushn = 1'b1;
        #1;
        checkOutput("reset_LEDn",   7'(LEDn), 7'd1);
        checkOutput("reset_c9",     7'(c9),   7'd0);
        checkOutput("reset_Digit1", Digit1,   7'b0000001);
        checkOutput("reset_Digit0", Digit0,   7'b0000001);

        applyStimulus(1, 1, 0, 1);
        idle(20, 1);

        applyStimulus(0, 1, 1, 1);
        runTo(12);
        checkOutput("twelve_Digit1", segTab[modelN / 10], 7'b1001111);
        idle(3, 1);

        applyStimulus(0, 1, 0, 0);
        idle(48, 1);

        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0);
        idle(16, 1);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, ($urandom_range(0, 15) != 0), ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 29) != 0));
        end

        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 1);
        runTo(99);
        idle(3 * PMOD, 1);

        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 1, 1, 1);
        runTo(57);
        @(posedge Clock);
        #3;
        Reset = 1'b1;
        #1;
        checkOutput("async_LEDn",   7'(LEDn), 7'd1);
        checkOutput("async_c9",     7'(c9),   7'd0);
        checkOutput("async_Digit1", Digit1,   7'b0000001);
        checkOutput("async_Digit0", Digit0,   7'b0000001);
        applyStimulus(1, 1, 0, 1);

        applyStimulus(0, 0, 1, 1);
        idle(40, 0);
        applyStimulus(0, 1, 0, 1);
        idle(12, 1);

        @(posedge Clock);
        #3;
        checkOutput("queue_drained", 7'(expQ.size()), 7'd0);
        stimDone = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
